// File: rtl/fifocntl_pkg.sv
// fifocntl_pkg: shared FSM states and receive FIFO word layout.
package fifocntl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam int MAX_BEATS = 4;
    localparam int BEAT_W    = 256;
    localparam int KEEP_W    = 32;

    localparam int LEN_LSB   = 0;
    localparam int LEN_W     = 8;
    localparam int DEST_LSB  = 8;
    localparam int DEST_W    = 16;
    localparam int BEAT0_LSB = 24;
    localparam int BEAT1_LSB = BEAT0_LSB + BEAT_W;
    localparam int BEAT2_LSB = BEAT1_LSB + BEAT_W;
    localparam int BEAT3_LSB = BEAT2_LSB + BEAT_W;
    localparam int FIFO_W    = BEAT3_LSB + BEAT_W;
endpackage

// File: rtl/rx_keep_decode.sv
// rx_keep_decode: highest set byte-enable index and all-zero flag.
module rx_keep_decode
    import fifocntl_pkg::*;
(
    input  logic [KEEP_W-1:0] keep,
    output logic [4:0]        hi_idx,
    output logic              zero
);
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) hi_idx = 5'(i);
        end
    end

    assign zero = ~|keep;
endmodule

// File: rtl/fifocntl_rx.sv
// fifocntl_rx: packs up to 4 AXI4-Stream beats into one receive FIFO word.
// Optional length check enabled by FIFOCNTL_RX_LENCHK_EN.
module fifocntl_rx
    import fifocntl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              inclk,
    input  logic              inrst,
    input  logic [255:0]      tdata,
    input  logic [31:0]       tkeep,
    input  logic [127:0]      tuser,
    input  logic              tvalid,
    output logic              tready,
    input  logic              tlast,
    input  logic              rxfifofull,
    output logic              rxfifowe,
    output logic [1047:0]     rx_fifo,
    output logic [CNT_W-1:0]  drop_cnt
);
    state_t           state;
    logic [2:0]       nbeat;
    logic [4:0]       hi_idx;
    logic             keep_zero;
    logic             acc;
    logic [1:0]       last_idx;
    logic             len_flag;
    logic [7:0]       code;
    logic [CNT_W-1:0] drop_nxt;

    rx_keep_decode u_keep (
        .keep   (tkeep),
        .hi_idx (hi_idx),
        .zero   (keep_zero)
    );

    assign acc      = tvalid & tready;
    assign last_idx = (state == IDLE) ? 2'd0 : nbeat[1:0];
    assign drop_nxt = (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
    assign rxfifowe = (state == WRITE) & ~rxfifofull;

`ifdef FIFOCNTL_RX_LENCHK_EN
    logic [15:0] len_q;
    logic [15:0] len_ref;
    logic [95:0] unused_tuser;

    assign unused_tuser = tuser[127:32];
    assign len_ref  = (state == IDLE) ? tuser[15:0] : len_q;
    assign len_flag = (16'({last_idx, hi_idx}) + 16'd1) != len_ref;

    always_ff @(posedge inclk) begin
        if (inrst)
            len_q <= '0;
        else if (state == IDLE && acc)
            len_q <= tuser[15:0];
    end
`else
    logic [111:0] unused_tuser;

    assign unused_tuser = {tuser[127:32], tuser[15:0]};
    assign len_flag = 1'b0;
`endif

    assign code = {len_flag, last_idx, hi_idx};

    always_ff @(posedge inclk) begin
        if (inrst) begin
            state    <= IDLE;
            tready   <= 1'b0;
            nbeat    <= '0;
            rx_fifo  <= '0;
            drop_cnt <= '0;
        end else begin
            tready <= 1'b1;
            unique case (state)
                IDLE: if (acc) begin
                    rx_fifo <= {{(3*BEAT_W){1'b0}}, tdata, tuser[31:16],
                                tlast ? code : 8'h00};
                    nbeat   <= 3'd1;
                    if (!tlast) begin
                        state <= RECV;
                    end else if (keep_zero) begin
                        drop_cnt <= drop_nxt;
                    end else begin
                        state  <= WRITE;
                        tready <= 1'b0;
                    end
                end
                RECV: if (acc) begin
                    if (nbeat == 3'(MAX_BEATS)) begin
                        // beat 5 of an oversize frame: discard to tlast
                        if (tlast) begin
                            state    <= IDLE;
                            drop_cnt <= drop_nxt;
                        end else begin
                            state <= DROP;
                        end
                    end else begin
                        rx_fifo[BEAT0_LSB + BEAT_W*int'(nbeat[1:0]) +: BEAT_W]
                            <= tdata;
                        nbeat <= nbeat + 3'd1;
                        if (tlast) begin
                            if (keep_zero) begin
                                state    <= IDLE;
                                drop_cnt <= drop_nxt;
                            end else begin
                                rx_fifo[LEN_LSB +: LEN_W] <= code;
                                state  <= WRITE;
                                tready <= 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!rxfifofull)
                        state <= IDLE;
                    else
                        tready <= 1'b0;
                end
                DROP: if (acc && tlast) begin
                    state    <= IDLE;
                    drop_cnt <= drop_nxt;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifocntl_rx.sv
// tb_fifocntl_rx: randomized frames checked against a frame-level model.
module tb_fifocntl_rx;
    logic          inclk = 0;
    logic          inrst = 1;
    logic [255:0]  tdata = '0;
    logic [31:0]   tkeep = '0;
    logic [127:0]  tuser = '0;
    logic          tvalid = 0;
    logic          tready;
    logic          tlast = 0;
    logic          rxfifofull = 0;
    logic          rxfifowe;
    logic [1047:0] rx_fifo;
    logic [15:0]   drop_cnt;

    fifocntl_rx #(.CNT_W(16)) dut (
        .inclk(inclk), .inrst(inrst), .tdata(tdata), .tkeep(tkeep),
        .tuser(tuser), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .rxfifofull(rxfifofull), .rxfifowe(rxfifowe), .rx_fifo(rx_fifo),
        .drop_cnt(drop_cnt)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        logic [7:0]   code;
        logic [15:0]  dest;
        logic [255:0] b [4];
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   writes_seen = 0;
    int   drop_exp = 0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    always @(negedge inclk) begin
        if (rxfifowe) begin
            writes_seen++;
            chk("we_while_full", 256'(rxfifofull), 256'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_write", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("len_code", 256'(rx_fifo[7:0]), 256'(e.code));
                chk("dest", 256'(rx_fifo[23:8]), 256'(e.dest));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("beat%0d", k),
                        rx_fifo[24 + 256*k +: 256], e.b[k]);
            end
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    // n beats; frame written iff n<=4 and last-beat keep is nonzero
    task automatic send_frame(input int n, input logic [31:0] lkeep,
                              input logic [15:0] dest, input logic [15:0] len,
                              input int full_cyc, input int gap);
        logic [255:0]  d [8];
        logic [1047:0] snap;
        exp_t          e;
        int            hi, w0, t;
        bit            wr;
        wr = (n <= 4) && (lkeep != 0);
        for (int b = 0; b < n; b++) d[b] = rnd256();
        if (wr) begin
            hi = $clog2({32'd0, lkeep} + 64'd1) - 1;
            e.dest = dest;
            for (int k = 0; k < 4; k++) e.b[k] = (k < n) ? d[k] : '0;
            e.code = 8'((n - 1) * 32 + hi);
`ifdef FIFOCNTL_RX_LENCHK_EN
            if (32 * (n - 1) + hi + 1 != int'(len)) e.code[7] = 1'b1;
`endif
            exp_q.push_back(e);
        end else begin
            drop_exp++;
        end
        w0 = writes_seen;
        for (int b = 0; b < n; b++) begin
            while ($urandom_range(99) < gap) begin
                tvalid = 0;
                tick();
            end
            tvalid = 1;
            tdata  = d[b];
            tlast  = (b == n - 1);
            tkeep  = tlast ? lkeep : $urandom;
            tuser  = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) tuser[31:0] = {dest, len};
            rxfifofull = tlast && (full_cyc > 0);
            t = 0;
            while (!tready && t < 20) begin
                tick();
                t++;
            end
            if (t >= 20) chk("tready_timeout", 256'd0, 256'd1);
            tick();
        end
        tvalid = 0;
        tlast  = 0;
        if (wr) begin
            snap = rx_fifo;
            for (int i = 0; i < full_cyc; i++) begin
                chk("tready_in_write", 256'(tready), 256'd0);
                chk("hold_while_full", 256'(rx_fifo == snap), 256'd1);
                tick();
            end
        end
        rxfifofull = 0;
        tick();
        chk("write_count", 256'(writes_seen - w0), 256'(wr ? 1 : 0));
        chk("drop_cnt", 256'(drop_cnt), 256'(drop_exp));
        chk("tready_idle", 256'(tready), 256'd1);
    endtask

    initial begin
        int n, fc;
        logic [31:0] k;
        logic [15:0] len;
        repeat (2) tick();
        chk("rst_tready", 256'(tready), 256'd0);
        chk("rst_fifo_zero", 256'(rx_fifo == '0), 256'd1);
        chk("rst_drop", 256'(drop_cnt), 256'd0);
        chk("rst_we", 256'(rxfifowe), 256'd0);
        inrst = 0;
        tick();
        chk("tready_after_rst", 256'(tready), 256'd1);

        send_frame(1, 32'h0000000F, 16'hABCD, 16'd4, 0, 0);
        send_frame(3, 32'hFFFFFFFF, 16'h1234, 16'd96, 0, 0);
        send_frame(3, 32'hFFFFFFFF, 16'h1234, 16'd90, 0, 0);
        send_frame(2, 32'h00000001, 16'h5555, 16'd33, 5, 0);
        send_frame(6, 32'h0000FFFF, 16'h0BAD, 16'd0, 0, 0);
        send_frame(1, 32'h00000003, 16'h00FE, 16'd2, 0, 0);
        send_frame(4, 32'h00000000, 16'h0001, 16'd0, 0, 0);
        send_frame(4, 32'h80000000, 16'hBEEF, 16'd128, 2, 0);
        send_frame(5, 32'h000000FF, 16'h0002, 16'd0, 0, 0);

        // reset after beat1 of a 4-beat frame
        begin
            int w0;
            w0 = writes_seen;
            for (int b = 0; b < 2; b++) begin
                tvalid = 1;
                tdata  = rnd256();
                tkeep  = '1;
                tuser  = {96'd0, 16'h7777, 16'd128};
                tlast  = 0;
                tick();
            end
            tvalid = 0;
            inrst  = 1;
            tick();
            inrst  = 0;
            drop_exp = 0;
            chk("midrst_tready", 256'(tready), 256'd0);
            chk("midrst_drop", 256'(drop_cnt), 256'd0);
            chk("midrst_fifo_zero", 256'(rx_fifo == '0), 256'd1);
            tick();
            chk("midrst_tready_up", 256'(tready), 256'd1);
            repeat (3) tick();
            chk("midrst_no_write", 256'(writes_seen - w0), 256'd0);
        end
        send_frame(1, 32'h0000000F, 16'hABCD, 16'd4, 0, 0);

        for (int f = 0; f < 40; f++) begin
            n  = $urandom_range(1, 6);
            k  = ($urandom_range(7) == 0) ? 32'd0
                 : (32'hFFFFFFFF >> $urandom_range(31));
            len = ($urandom_range(1) == 1) ? 16'($urandom)
                  : 16'(32 * (n - 1) + $clog2({32'd0, k} + 64'd1));
            fc = $urandom_range(3);
            send_frame(n, k, 16'($urandom), len, fc, 25);
        end
        repeat (3) tick();
        chk("queue_empty", 256'(exp_q.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
